framebuf_arbiter: RTL
=====================

FRAMEBUF_ARBITER -- requirements
Module: framebuf_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, giving the frame-buffer word address width.
REQ-002 SHALL have parameter DATA_W, default 8, giving the pixel width (R3 G3 B2 packing).
REQ-003 SHALL have parameter H_VISIBLE, default 640, giving the visible pixels per line used for address generation.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, giving the write-buffer entries (power of two).
REQ-005 VGACLK  in  1  sole clock; all logic rising-edge.
REQ-006 RST_IN  in  1  reset, asynchronous, active-high.
REQ-007 DISPLAY_EN  in  1  scan timing visible-area flag.
REQ-008 POS_X  in  11  visible-relative pixel column (valid when DISPLAY_EN).
REQ-009 POS_Y  in  11  visible-relative pixel row (valid when DISPLAY_EN).
REQ-010 PIXEL_DATA  out  DATA_W  registered pixel to the colour stage.
REQ-011 PIXEL_VALID  out  1  PIXEL_DATA carries a fetched pixel.
REQ-012 WR_VALID  in  1  writer request.
REQ-013 WR_READY  out  1  write buffer can accept.
REQ-014 WR_ADDR  in  ADDR_W  writer address.
REQ-015 WR_DATA  in  DATA_W  writer data.
REQ-016 MEM_ADDR  out  ADDR_W  single-port memory address.
REQ-017 MEM_WE  out  1  memory write strobe.
REQ-018 MEM_WDATA  out  DATA_W  memory write data.
REQ-019 MEM_RDATA  in  DATA_W  memory read data, valid one cycle after address.
REQ-020 WR_LEVEL  out  log2(FIFO_DEPTH)+1  write-buffer occupancy.

Function
REQ-021 SHALL arbitrate the single memory port each cycle: display read has absolute priority; write slot granted only when DISPLAY_EN=0 and buffer non-empty.
REQ-022 SHALL run FSM states IDLE, SCAN, DRAIN; IDLE->SCAN on DISPLAY_EN=1; IDLE->DRAIN on DISPLAY_EN=0 and buffer non-empty; SCAN->DRAIN/IDLE on DISPLAY_EN=0 by buffer state; DRAIN->SCAN on DISPLAY_EN=1 (pre-empts, no write that cycle); DRAIN->IDLE when buffer empties.
REQ-023 SHALL drive MEM_ADDR combinationally in a display cycle as POS_Y*H_VISIBLE+POS_X, computed at ADDR_W bits, truncated (no saturation).
REQ-024 SHALL in a write slot drive MEM_WE=1, MEM_ADDR/MEM_WDATA from buffer head, and pop exactly one entry.
REQ-025 SHALL drive MEM_WE=0 and MEM_ADDR=0 in IDLE-slot cycles.
REQ-026 SHALL register PIXEL_DATA<=MEM_RDATA and PIXEL_VALID<=1 two cycles after a display cycle; otherwise PIXEL_DATA<=0, PIXEL_VALID<=0 (2-cycle fixed latency).
REQ-027 SHALL implement write buffer as FIFO, push on WR_VALID&&WR_READY, WR_READY=!full, computed from registered level only.
REQ-028 SHALL not bypass: an entry pushed in cycle t is writable no earlier than cycle t+1.
REQ-029 SHALL, when full and a pop occurs, still hold WR_READY=0 that cycle; WR_READY rises next cycle.
REQ-030 SHALL on simultaneous push and pop keep WR_LEVEL unchanged and preserve order.
REQ-031 SHALL write in FIFO order; a later write to same address wins.
REQ-032 SHALL wrap FIFO pointers modulo FIFO_DEPTH without loss.

Reset
REQ-033 SHALL while RST_IN=1 force state IDLE, FIFO empty, WR_LEVEL=0, PIXEL_DATA=0, PIXEL_VALID=0, MEM_WE=0, MEM_ADDR=0, WR_READY=0.
REQ-034 SHALL raise WR_READY in the first cycle after RST_IN deasserts.
REQ-035 SHALL discard buffered writes and in-flight reads on reset mid-operation; no MEM_WE pulse during or immediately after reset.

Verification
REQ-036 Reset mid-DRAIN with 3 entries -> MEM_WE=0 at once, WR_LEVEL=0, after release WR_READY=1, no stale writes.
REQ-037 DISPLAY_EN=1, POS_Y=2, POS_X=5, MEM_RDATA echoes address LSBs -> MEM_ADDR=1285, PIXEL_DATA=0x05 with PIXEL_VALID two cycles later.
REQ-038 DISPLAY_EN=1 continuously, 4 writes pushed -> WR_LEVEL=4, WR_READY=0, MEM_WE never 1; drop DISPLAY_EN -> 4 writes on consecutive cycles in order, WR_READY=1 after first pop+1.
REQ-039 DISPLAY_EN rises during DRAIN with 2 entries left -> that cycle is a read, MEM_WE=0, WR_LEVEL stays 2 until blanking.
REQ-040 Full buffer, blanking, WR_VALID held -> level stays 4 on push+pop, 10 writes complete in order across pointer wrap.

Source files
------------

// File: rtl/framebuf_arbiter.sv
// framebuf_arbiter
//   Shares one single-port frame-buffer memory between the display scan-out
//   (reads, absolute priority) and a buffered pixel writer (writes only in
//   blanking). Reads return two cycles after the address cycle.
//
// Ports
//   VGACLK, RST_IN           clock (rising edge), async active-high reset
//   DISPLAY_EN, POS_X, POS_Y scan timing: visible flag and visible-relative position
//   PIXEL_DATA, PIXEL_VALID  registered fetched pixel to the colour stage
//   WR_VALID, WR_READY       writer handshake
//   WR_ADDR, WR_DATA         writer address / pixel
//   MEM_ADDR, MEM_WE         single-port memory address / write strobe
//   MEM_WDATA, MEM_RDATA     memory write data / read data (one-cycle latency)
//   WR_LEVEL                 write-buffer occupancy
module framebuf_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int H_VISIBLE  = 640,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          VGACLK,
    input  logic                          RST_IN,
    input  logic                          DISPLAY_EN,
    input  logic [10:0]                   POS_X,
    input  logic [10:0]                   POS_Y,
    output logic [DATA_W-1:0]             PIXEL_DATA,
    output logic                          PIXEL_VALID,
    input  logic                          WR_VALID,
    output logic                          WR_READY,
    input  logic [ADDR_W-1:0]             WR_ADDR,
    input  logic [DATA_W-1:0]             WR_DATA,
    output logic [ADDR_W-1:0]             MEM_ADDR,
    output logic                          MEM_WE,
    output logic [DATA_W-1:0]             MEM_WDATA,
    input  logic [DATA_W-1:0]             MEM_RDATA,
    output logic [$clog2(FIFO_DEPTH):0]   WR_LEVEL
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              empty, full, push, pop, rd_slot, rd_d1;
    logic [ADDR_W-1:0] scan_addr;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    // Ready comes from the registered level only, so a pop in a full cycle
    // does not open the buffer until the following cycle.
    assign WR_READY = !RST_IN && !full;
    assign push     = WR_VALID && WR_READY;
    assign WR_LEVEL = level;

    // Linear pixel address, wraps at ADDR_W bits.
    assign scan_addr = ADDR_W'(POS_Y) * ADDR_W'(H_VISIBLE) + ADDR_W'(POS_X);

    // The slot owner is decided every cycle from the live scan flag, so the
    // next state is also the role of the current memory cycle.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    if (DISPLAY_EN) state_nxt = SCAN;
                     else if (!empty) state_nxt = DRAIN;
            SCAN:    if (DISPLAY_EN) state_nxt = SCAN;
                     else if (!empty) state_nxt = DRAIN;
            DRAIN:   if (DISPLAY_EN) state_nxt = SCAN;   // display pre-empts drain
                     else if (!empty) state_nxt = DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_slot   = 1'b0;
        pop       = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        // Scan inputs are live during reset; keep the port quiet until release.
        if (!RST_IN) begin
            case (state_nxt)
                SCAN: begin
                    rd_slot  = 1'b1;
                    MEM_ADDR = scan_addr;
                end
                DRAIN: begin
                    pop       = 1'b1;
                    MEM_WE    = 1'b1;
                    MEM_ADDR  = fifo_addr[rd_ptr];
                    MEM_WDATA = fifo_data[rd_ptr];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge VGACLK or posedge RST_IN) begin
        if (RST_IN) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            rd_d1       <= 1'b0;
            PIXEL_VALID <= 1'b0;
            PIXEL_DATA  <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;   // power-of-two depth wraps naturally
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
            // Memory returns data the cycle after the address; capture it then.
            rd_d1       <= rd_slot;
            PIXEL_VALID <= rd_d1;
            PIXEL_DATA  <= rd_d1 ? MEM_RDATA : '0;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by level/pointers.
    always_ff @(posedge VGACLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= WR_ADDR;
            fifo_data[wr_ptr] <= WR_DATA;
        end
    end

endmodule
